reset_seq_ctrl: RTL and testbench

Parametrised successor to the fixed "hold reset ~4 cycles, then release" bench start-up. Sequences the release of N_CH active-low reset domains with programmable hold and stagger gaps. Watches a halt/end-of-test signal with a cycle timeout, and supports re-sequencing on a soft-reset request. Sits in the test top between the clock generator and the pipeline core plus its peripheral reset domains; it is synthesizable and is reused on FPGA bring-up.

---
 rtl/reset_seq_pkg.sv | 25 ++
 rtl/reset_seq_ctrl_if.sv | 41 ++++
 rtl/seq_cycle_counter.sv | 29 ++
 rtl/reset_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_reset_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset sequencer.
//   seq_state_t : sequencer state encoding
//   DEF_*       : default parameter values
//   ch_idx_w()  : channel index width, $clog2(N_CH) but never below 1
package reset_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        STAGGER,
        RUN,
        DONE,
        TIMEOUT
    } seq_state_t;

    localparam int DEF_N_CH           = 4;
    localparam int DEF_HOLD_CYCLES    = 4;
    localparam int DEF_GAP_CYCLES     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 10000;
    localparam int DEF_CNT_W          = 32;

    function automatic int ch_idx_w(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/reset_seq_ctrl_if.sv
// Handshake bundle between the reset sequencer and the test top.
//   soft_rst_req : restart request (into sequencer)
//   halt         : end-of-test level (into sequencer)
//   reset_n_out  : per-channel active-low resets
//   all_released : every channel released
//   done         : sticky, halt seen in RUN
//   timeout      : sticky, RUN budget exhausted
//   run_cycles   : RUN edge count, only when RESET_SEQ_RUN_CNT_EN is defined
// modport master = sequencer side, modport slave = test top side.
interface reset_seq_ctrl_if #(
    parameter int N_CH = 4
`ifdef RESET_SEQ_RUN_CNT_EN
    , parameter int CNT_W = 32
`endif
);
    logic            soft_rst_req;
    logic            halt;
    logic [N_CH-1:0] reset_n_out;
    logic            all_released;
    logic            done;
    logic            timeout;
`ifdef RESET_SEQ_RUN_CNT_EN
    logic [CNT_W-1:0] run_cycles;
`endif

    modport master (
        input  soft_rst_req, halt,
        output reset_n_out, all_released, done, timeout
`ifdef RESET_SEQ_RUN_CNT_EN
        , output run_cycles
`endif
    );

    modport slave (
        output soft_rst_req, halt,
        input  reset_n_out, all_released, done, timeout
`ifdef RESET_SEQ_RUN_CNT_EN
        , input run_cycles
`endif
    );
endinterface

// File: rtl/seq_cycle_counter.sv
// Shared phase counter for hold, gap and timeout intervals.
//   clk, reset : clock and synchronous active-high reset
//   clr        : zero the count (wins over en)
//   en         : count this edge
//   limit      : phase length in edges (>= 1)
//   tc         : this enabled edge is the limit-th edge of the phase
module seq_cycle_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Looks one edge ahead so the phase action lands on the limit-th edge.
    assign tc = en && (cnt == limit - CNT_W'(1));
endmodule

// File: rtl/reset_seq_ctrl.sv
// Staggered release of N_CH active-low reset domains, then end-of-test watch.
//   clk, reset : clock and synchronous active-high reset
//   bus        : reset_seq_ctrl_if.master (soft_rst_req, halt in; resets/flags out)
// Optional: RESET_SEQ_RUN_CNT_EN adds the run_cycles report counter.
//
// state   | meaning
// HOLD    | all channels asserted, counting HOLD_CYCLES
// STAGGER | releasing channels 1..N_CH-1, GAP_CYCLES apart
// RUN     | all released, waiting for halt or timeout
// DONE    | halt seen, terminal until reset/soft reset
// TIMEOUT | RUN budget spent, terminal until reset/soft reset
module reset_seq_ctrl
    import reset_seq_pkg::*;
#(
    parameter int N_CH           = DEF_N_CH,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    reset_seq_ctrl_if.master  bus
);
    localparam int CH_W = ch_idx_w(N_CH);

    seq_state_t       state_q, state_d;
    logic [N_CH-1:0]  rst_n_q, rst_n_d;
    logic             all_q, all_d;
    logic             done_q, done_d;
    logic             to_q, to_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             cnt_clr, cnt_en, cnt_tc;
    logic [CNT_W-1:0] cnt_limit;

    seq_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (cnt_limit),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HOLD;
            rst_n_q <= '0;
            all_q   <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            rst_n_q <= rst_n_d;
            all_q   <= all_d;
            done_q  <= done_d;
            to_q    <= to_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_n_d   = rst_n_q;
        all_d     = all_q;
        done_d    = done_q;
        to_d      = to_q;
        ch_d      = ch_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        cnt_limit = CNT_W'(HOLD_CYCLES);

        if (bus.soft_rst_req) begin
            state_d = HOLD;
            rst_n_d = '0;
            all_d   = 1'b0;
            done_d  = 1'b0;
            to_d    = 1'b0;
            ch_d    = '0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                HOLD: begin
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        rst_n_d[0] = 1'b1;
                        cnt_clr    = 1'b1;
                        if (N_CH == 1) begin
                            all_d   = 1'b1;
                            state_d = RUN;
                        end else begin
                            ch_d    = CH_W'(1);
                            state_d = STAGGER;
                        end
                    end
                end
                STAGGER: begin
                    cnt_en    = 1'b1;
                    cnt_limit = CNT_W'(GAP_CYCLES);
                    if (cnt_tc) begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (ch_q == CH_W'(i)) rst_n_d[i] = 1'b1;
                        end
                        cnt_clr = 1'b1;
                        if (ch_q == CH_W'(N_CH - 1)) begin
                            all_d   = 1'b1;
                            state_d = RUN;
                        end else begin
                            ch_d = ch_q + CH_W'(1);
                        end
                    end
                end
                RUN: begin
                    cnt_en    = 1'b1;
                    cnt_limit = CNT_W'(TIMEOUT_CYCLES);
                    // halt wins over a timeout landing on the same edge
                    if (bus.halt) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (cnt_tc) begin
                        to_d    = 1'b1;
                        state_d = TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.reset_n_out  = rst_n_q;
    assign bus.all_released = all_q;
    assign bus.done         = done_q;
    assign bus.timeout      = to_q;

`ifdef RESET_SEQ_RUN_CNT_EN
    // Counts every RUN edge including the exit edge, then freezes.
    logic [CNT_W-1:0] run_q;

    always_ff @(posedge clk) begin
        if (reset || bus.soft_rst_req) begin
            run_q <= '0;
        end else if (state_q == RUN) begin
            run_q <= run_q + CNT_W'(1);
        end
    end

    assign bus.run_cycles = run_q;
`endif
endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Scoreboard bench for reset_seq_ctrl: a 4-channel instance and a 1-channel
// instance share clock, reset, soft_rst_req and halt. Stimulus queues
// (edge, field, value) expectations; the monitor checks them at negedge.
module tb_reset_seq_ctrl;

    localparam int F_RSTN  = 0;
    localparam int F_ALL   = 1;
    localparam int F_DONE  = 2;
    localparam int F_TO    = 3;
    localparam int F_RUNC  = 4;
    localparam int F_RSTN1 = 5;
    localparam int F_ALL1  = 6;
    localparam int F_TO1   = 7;

    typedef struct {
        int          cyc;
        int          fld;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic soft_rst_req = 1'b0;
    logic halt = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_c = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef RESET_SEQ_RUN_CNT_EN
    reset_seq_ctrl_if #(.N_CH(4), .CNT_W(32)) bus4 ();
    reset_seq_ctrl_if #(.N_CH(1), .CNT_W(32)) bus1 ();
`else
    reset_seq_ctrl_if #(.N_CH(4)) bus4 ();
    reset_seq_ctrl_if #(.N_CH(1)) bus1 ();
`endif

    assign bus4.soft_rst_req = soft_rst_req;
    assign bus4.halt         = halt;
    assign bus1.soft_rst_req = soft_rst_req;
    assign bus1.halt         = halt;

    reset_seq_ctrl #(.N_CH(4), .HOLD_CYCLES(4), .GAP_CYCLES(2),
                     .TIMEOUT_CYCLES(20), .CNT_W(32)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4));

    reset_seq_ctrl #(.N_CH(1), .HOLD_CYCLES(4), .GAP_CYCLES(2),
                     .TIMEOUT_CYCLES(20), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    function automatic logic [31:0] sample(input int f);
        case (f)
            F_RSTN:  return {28'd0, bus4.reset_n_out};
            F_ALL:   return {31'd0, bus4.all_released};
            F_DONE:  return {31'd0, bus4.done};
            F_TO:    return {31'd0, bus4.timeout};
`ifdef RESET_SEQ_RUN_CNT_EN
            F_RUNC:  return bus4.run_cycles;
`endif
            F_RSTN1: return {31'd0, bus1.reset_n_out};
            F_ALL1:  return {31'd0, bus1.all_released};
            F_TO1:   return {31'd0, bus1.timeout};
            default: return 32'hdead_beef;
        endcase
    endfunction

    function automatic string fname(input int f);
        case (f)
            F_RSTN:  return "reset_n_out";
            F_ALL:   return "all_released";
            F_DONE:  return "done";
            F_TO:    return "timeout";
            F_RUNC:  return "run_cycles";
            F_RSTN1: return "n1.reset_n_out";
            F_ALL1:  return "n1.all_released";
            F_TO1:   return "n1.timeout";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: outputs are stable at negedge; cyc equals the last posedge index.
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc <= cyc) begin
                checks++;
                if (sbq[i].cyc < cyc) begin
                    errors++;
                    $display("FAIL %s @edge %0d: not sampled in time (expected %0h)",
                             fname(sbq[i].fld), sbq[i].cyc, sbq[i].exp);
                end else begin
                    act = sample(sbq[i].fld);
                    if (act !== sbq[i].exp) begin
                        errors++;
                        $display("FAIL %s @edge %0d: got %0h expected %0h",
                                 fname(sbq[i].fld), cyc, act, sbq[i].exp);
                    end
                end
                sbq.delete(i);
            end
        end
    end

    task automatic push(input int c, input int f, input logic [31:0] v);
        exp_t e;
        e.cyc = c;
        e.fld = f;
        e.exp = v;
        sbq.push_back(e);
        if (c > last_c) last_c = c;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_cleared(input int c);
        push(c, F_RSTN, 32'h0);
        push(c, F_ALL,  32'h0);
        push(c, F_DONE, 32'h0);
        push(c, F_TO,   32'h0);
`ifdef RESET_SEQ_RUN_CNT_EN
        push(c, F_RUNC, 32'h0);
`endif
    endtask

    // Hold reset for n edges; b returns the edge index just before edge 1.
    task automatic do_reset(input int n, output int b);
        int c0;
        c0 = cyc;
        reset = 1'b1;
        push_cleared(c0 + n);
        push(c0 + n, F_RSTN1, 32'h0);
        push(c0 + n, F_ALL1,  32'h0);
        repeat (n) @(negedge clk);
        reset = 1'b0;
        b = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        @(negedge clk);

        // Release sequence and timeout after reset held 3 cycles
        do_reset(3, b);
        push(b + 4,  F_RSTN, 32'h1);
        push(b + 5,  F_RSTN, 32'h1);
        push(b + 6,  F_RSTN, 32'h3);
        push(b + 8,  F_RSTN, 32'h7);
        push(b + 9,  F_RSTN, 32'h7);
        push(b + 9,  F_ALL,  32'h0);
        push(b + 10, F_RSTN, 32'hf);
        push(b + 10, F_ALL,  32'h1);
        push(b + 3,  F_RSTN1, 32'h0);
        push(b + 4,  F_RSTN1, 32'h1);
        push(b + 4,  F_ALL1,  32'h1);
        push(b + 23, F_TO1,   32'h0);
        push(b + 24, F_TO1,   32'h1);
        push(b + 29, F_TO,   32'h0);
        push(b + 30, F_TO,   32'h1);
        push(b + 30, F_DONE, 32'h0);
        push(b + 31, F_RSTN, 32'hf);
`ifdef RESET_SEQ_RUN_CNT_EN
        push(b + 30, F_RUNC, 32'd20);
        push(b + 31, F_RUNC, 32'd20);
`endif
        wait_to(b + 32);

        // halt sampled on RUN edge 5
        do_reset(3, b);
        wait_to(b + 14);
        halt = 1'b1;
        push(b + 14, F_DONE, 32'h0);
        push(b + 15, F_DONE, 32'h1);
        push(b + 30, F_TO,   32'h0);
        push(b + 40, F_DONE, 32'h1);
        push(b + 40, F_TO,   32'h0);
`ifdef RESET_SEQ_RUN_CNT_EN
        push(b + 15, F_RUNC, 32'd5);
        push(b + 25, F_RUNC, 32'd5);
`endif
        @(negedge clk);
        halt = 1'b0;
        wait_to(b + 41);

        // soft reset out of DONE, then halt on the 20th RUN edge
        soft_rst_req = 1'b1;
        b = cyc + 1;
        push_cleared(b);
        push(b + 4,  F_RSTN, 32'h1);
        push(b + 10, F_RSTN, 32'hf);
        @(negedge clk);
        soft_rst_req = 1'b0;
        wait_to(b + 29);
        halt = 1'b1;
        push(b + 30, F_DONE, 32'h1);
        push(b + 30, F_TO,   32'h0);
        push(b + 31, F_TO,   32'h0);
`ifdef RESET_SEQ_RUN_CNT_EN
        push(b + 31, F_RUNC, 32'd20);
`endif
        @(negedge clk);
        halt = 1'b0;
        wait_to(b + 32);

        // soft reset sampled at edge 8, mid-STAGGER
        do_reset(3, b);
        wait_to(b + 7);
        soft_rst_req = 1'b1;
        push(b + 7,  F_RSTN, 32'h3);
        push(b + 8,  F_RSTN, 32'h0);
        push(b + 8,  F_DONE, 32'h0);
        push(b + 8,  F_ALL,  32'h0);
        push(b + 11, F_RSTN, 32'h0);
        push(b + 12, F_RSTN, 32'h1);
        push(b + 14, F_RSTN, 32'h3);
        push(b + 17, F_ALL,  32'h0);
        push(b + 18, F_RSTN, 32'hf);
        push(b + 18, F_ALL,  32'h1);
        @(negedge clk);
        soft_rst_req = 1'b0;

        // reset and soft reset together mid-RUN: reset dominates
        wait_to(b + 22);
        reset = 1'b1;
        soft_rst_req = 1'b1;
        push_cleared(b + 24);
        push(b + 24, F_RSTN1, 32'h0);
        push(b + 24, F_ALL1,  32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        soft_rst_req = 1'b0;
        b = cyc;
        push(b + 3,  F_RSTN, 32'h0);
        push(b + 4,  F_RSTN, 32'h1);
        push(b + 10, F_RSTN, 32'hf);
        push(b + 10, F_ALL,  32'h1);
        push(b + 3,  F_ALL1,  32'h0);
        push(b + 4,  F_RSTN1, 32'h1);
        push(b + 4,  F_ALL1,  32'h1);

        wait_to(last_c + 2);
        if (sbq.size() != 0) begin
            $display("FAIL scoreboard: %0d expectations left unchecked, required 0", sbq.size());
            errors += sbq.size();
            checks += sbq.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
